s3_trit_packer: RTL and testbench
=================================

S3_TRIT_PACKER -- requirements
Module: s3_trit_packer

Interface
REQ-001 SHALL have parameter BYTES_PER_POLY, default 140, the number of packed bytes per polynomial (700 trits / 5).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port trit_in  input  2  mod-3 coefficient from the mod-3 reduction stage; legal values are 0, 1 and 2.
REQ-005 SHALL have port trit_valid  input  1  trit_in is valid this cycle.
REQ-006 SHALL have port trit_last  input  1  qualifies trit_in as the final trit of the polynomial.
REQ-007 SHALL have port trit_ready  output  1  the packer accepts trit_in this cycle.
REQ-008 SHALL have port byte_out  output  8  packed byte.
REQ-009 SHALL have port byte_valid  output  1  byte_out is valid.
REQ-010 SHALL have port byte_last  output  1  qualifies byte_out as the final byte of the polynomial.
REQ-011 SHALL have port byte_ready  input  1  the consumer accepts byte_out this cycle.

Function
REQ-012 SHALL accept a trit on any cycle where trit_valid and trit_ready are both high; no other cycle is an accept.
REQ-013 SHALL pack trits in groups of five as byte = t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4, where t0 is the first-accepted trit of the group; the maximum value is 242.
REQ-014 SHALL keep a group counter (0..4), an 8-bit accumulator and a weight register (1, 3, 9, 27, 81); on each accept: accumulator += trit*weight, weight *= 3, counter += 1.
REQ-015 SHALL treat trit_in = 3 as 0 (3 mod 3).
REQ-016 SHALL complete a group on the accept of the fifth trit, or on the accept of any trit with trit_last high (partial group; the missing high trits are 0).
REQ-017 On group completion, SHALL load byte_out with the final sum, assert byte_valid on the next cycle (latency 1), and clear the counter, accumulator and weight (weight to 1) in the same edge.
REQ-018 SHALL have a single-entry output register: byte_out, byte_valid and byte_last stay stable while byte_valid is high and byte_ready is low.
REQ-019 SHALL drop byte_valid after a cycle with byte_valid and byte_ready both high, unless a new group completes in that same cycle, in which case the new byte is loaded back-to-back with no bubble.
REQ-020 SHALL drive trit_ready = NOT(group-completing accept would occur) OR NOT byte_valid OR byte_ready, so it stalls only when a completing trit meets a full, unconsumed output register; non-completing trits are always accepted.
REQ-021 SHALL count emitted bytes 0..BYTES_PER_POLY-1 and assert byte_last on the byte whose index is BYTES_PER_POLY-1, or on the byte produced by a trit_last completion, whichever occurs first; the byte count SHALL then wrap to 0.
REQ-022 trit_last on the fifth trit of a group SHALL produce a single byte, not a second empty byte.
REQ-023 SHALL never emit a byte when no trit of the current group has been accepted.

Reset
REQ-024 While rst is high at a clock edge, SHALL clear byte_valid, byte_last, byte_out (to 0x00), the counter, the accumulator, the byte count, and set the weight to 1; any partial group or unconsumed byte is discarded.
REQ-025 SHALL hold trit_ready low in every cycle in which rst is high, and high in the first cycle after reset is released.

Verification
REQ-026 Trits 1,2,0,1,2 with byte_ready=1 -> byte_out = 1+6+0+27+162 = 196 (0xC4), byte_valid high for exactly one cycle, one cycle after the fifth accept.
REQ-027 Trits 2,2,2,2,2 followed by trits 0,0,0,0,0 with byte_ready=0 -> first byte 0xF2 held stable; trit_ready low on the tenth trit until byte_ready pulses; second byte 0x00.
REQ-028 Trits 2,1 with trit_last on the second trit -> byte_out = 2+3 = 5, byte_last=1, after which the counter restarts at t0 for the next polynomial.
REQ-029 700 random trits with random byte_ready, checked against the reference packing -> exactly 140 bytes out, byte_last only on byte 139, no lost or duplicated bytes.
REQ-030 rst asserted after the third trit of a group -> no byte emitted; the next five trits 1,0,0,0,0 give 0x01.
REQ-031 trit_in = 3 inside a group -> result identical to that trit being 0.

Source files
------------

// File: rtl/s3_trit_packer_if.sv
// Trit-to-byte packer stream bundle: trit stream in, packed byte stream out.
// Latency: n/a (signal bundle only).
// Backpressure: trit_ready and byte_ready are plain valid/ready handshakes.
// Ports:
//   trit_in/trit_valid/trit_last/trit_ready : mod-3 coefficient stream
//   byte_out/byte_valid/byte_last/byte_ready : packed byte stream
//   modport slave  = the packer, modport master = the environment driving it
interface s3_trit_packer_if;
  logic [1:0] trit_in;
  logic       trit_valid;
  logic       trit_last;
  logic       trit_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;

  modport master (
    output trit_in, trit_valid, trit_last, byte_ready,
    input  trit_ready, byte_out, byte_valid, byte_last
  );

  modport slave (
    input  trit_in, trit_valid, trit_last, byte_ready,
    output trit_ready, byte_out, byte_valid, byte_last
  );
endinterface

// File: rtl/s3_trit_packer.sv
// Packs mod-3 trits five per byte: byte = t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4.
// Latency: byte_valid rises one cycle after the group-completing trit is accepted.
// Backpressure: only a group-completing trit stalls, and only while the output byte is unconsumed.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : s3_trit_packer_if.slave (trit stream in, byte stream out)
module s3_trit_packer #(
  parameter int BYTES_PER_POLY = 140
) (
  input  logic               clk,
  input  logic               rst,
  s3_trit_packer_if.slave    bus
);

  localparam int CW = (BYTES_PER_POLY > 1) ? $clog2(BYTES_PER_POLY) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BYTES_PER_POLY - 1);

  logic [2:0]    grp_cnt;
  logic [7:0]    acc;
  logic [7:0]    wgt;
  logic [CW-1:0] byte_cnt;

  logic [7:0]    out_dat;
  logic          out_vld;
  logic          out_last;

  logic [1:0]    trit_val;
  logic          completing;
  logic          accept;
  logic          trit_rdy;
  logic [7:0]    sum;

  always_comb begin
    // The value 3 is congruent to 0 mod 3.
    trit_val   = (bus.trit_in == 2'd3) ? 2'd0 : bus.trit_in;
    // A valid trit would close the group if it is the fifth or is marked last;
    // a last on the fifth trit therefore still produces exactly one byte.
    completing = bus.trit_valid && ((grp_cnt == 3'd4) || bus.trit_last);
    // Stall only when a closing trit meets a held, unconsumed output byte.
    trit_rdy   = !rst && (!completing || !out_vld || bus.byte_ready);
    accept     = bus.trit_valid && trit_rdy;
    // Cannot overflow: the largest possible group sum is 242.
    sum        = acc + ({6'd0, trit_val} * wgt);
  end

  assign bus.trit_ready = trit_rdy;
  assign bus.byte_out   = out_dat;
  assign bus.byte_valid = out_vld;
  assign bus.byte_last  = out_last;

  // Group accumulator: running sum, current positional weight, trits so far.
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_cnt <= 3'd0;
      acc     <= 8'd0;
      wgt     <= 8'd1;
    end else if (accept) begin
      if (completing) begin
        grp_cnt <= 3'd0;
        acc     <= 8'd0;
        wgt     <= 8'd1;
      end else begin
        grp_cnt <= grp_cnt + 3'd1;
        acc     <= sum;
        wgt     <= (wgt << 1) + wgt;
      end
    end
  end

  // Single-entry output register with byte-in-polynomial counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_dat  <= 8'd0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      byte_cnt <= '0;
    end else if (accept && completing) begin
      // A completing accept implies the register is empty or draining this
      // cycle, so the new byte replaces it with no bubble.
      out_dat  <= sum;
      out_vld  <= 1'b1;
      out_last <= bus.trit_last || (byte_cnt == LAST_IDX);
      byte_cnt <= (bus.trit_last || (byte_cnt == LAST_IDX)) ? '0 : byte_cnt + 1'b1;
    end else if (out_vld && bus.byte_ready) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_s3_trit_packer.sv
// Directed and randomized bench for s3_trit_packer with a queue-based packing model.
module tb_s3_trit_packer;

  localparam int NBYTES = 140;

  typedef struct {
    logic [7:0] dat;
    logic       last;
  } exp_t;

  logic clk;
  logic rst;

  s3_trit_packer_if ifc ();

  s3_trit_packer #(.BYTES_PER_POLY(NBYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  // Reference model state: trits of the open group, bytes in this polynomial.
  int   grp[$];
  int   nbytes = 0;
  exp_t exp_q[$];

  // Monitor bookkeeping.
  int   bytes_seen = 0;
  int   lasts_seen = 0;
  int   last_at    = 0;
  bit   hold       = 1'b0;
  logic [7:0] hold_dat;
  logic       hold_last;
  bit   rnd_ready  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [1:0] t, input bit last);
    exp_t e;
    int   v;
    int   w;
    grp.push_back(int'(t) % 3);
    if (grp.size() == 5 || last) begin
      v = 0;
      w = 1;
      foreach (grp[i]) begin
        v += grp[i] * w;
        w *= 3;
      end
      e.dat  = v[7:0];
      e.last = last || (nbytes == NBYTES - 1);
      nbytes = e.last ? 0 : nbytes + 1;
      exp_q.push_back(e);
      grp.delete();
    end
  endtask

  task automatic model_reset();
    grp.delete();
    exp_q.delete();
    nbytes = 0;
  endtask

  // Present one trit and hold it until accepted (bounded).
  task automatic send_trit(input logic [1:0] t, input bit last);
    bit rdy;
    ifc.trit_in    = t;
    ifc.trit_valid = 1'b1;
    ifc.trit_last  = last;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (rnd_ready) ifc.byte_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      rdy = ifc.trit_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        model_push(t, last);
        return;
      end
    end
    check("accept_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic idle();
    ifc.trit_valid = 1'b0;
    ifc.trit_last  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    ifc.trit_valid = 1'b0;
    ifc.trit_last  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check("rst_trit_ready", 32'(ifc.trit_ready), 32'd0);
    check("rst_byte_valid", 32'(ifc.byte_valid), 32'd0);
    check("rst_byte_out",   32'(ifc.byte_out),   32'd0);
    check("rst_byte_last",  32'(ifc.byte_last),  32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_trit_ready", 32'(ifc.trit_ready), 32'd1);
  endtask

  // Output monitor: stability while stalled, and every handshaken byte
  // against the model queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 32'(ifc.byte_valid), 32'd1);
        check("hold_dat",   32'(ifc.byte_out),   32'(hold_dat));
        check("hold_last",  32'(ifc.byte_last),  32'(hold_last));
      end
      if (ifc.byte_valid && ifc.byte_ready) begin
        bytes_seen++;
        if (exp_q.size() == 0) begin
          check("spurious_byte", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("byte_dat",  32'(ifc.byte_out),  32'(e.dat));
          check("byte_last", 32'(ifc.byte_last), 32'(e.last));
        end
        if (ifc.byte_last) begin
          lasts_seen++;
          last_at = bytes_seen;
        end
      end
      hold      = ifc.byte_valid && !ifc.byte_ready;
      hold_dat  = ifc.byte_out;
      hold_last = ifc.byte_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_bytes;
    int base_lasts;
    logic [1:0] t;

    rst            = 1'b1;
    ifc.trit_in    = 2'd0;
    ifc.trit_valid = 1'b0;
    ifc.trit_last  = 1'b0;
    ifc.byte_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("init_trit_ready", 32'(ifc.trit_ready), 32'd0);
    check("init_byte_valid", 32'(ifc.byte_valid), 32'd0);
    check("init_byte_out",   32'(ifc.byte_out),   32'd0);
    rst = 1'b0;
    #1;
    check("init_release_ready", 32'(ifc.trit_ready), 32'd1);

    // 1,2,0,1,2 -> 0xC4, valid for exactly one cycle.
    send_trit(2'd1, 1'b0);
    send_trit(2'd2, 1'b0);
    send_trit(2'd0, 1'b0);
    send_trit(2'd1, 1'b0);
    check("c4_not_early", 32'(ifc.byte_valid), 32'd0);
    send_trit(2'd2, 1'b0);
    check("c4_valid", 32'(ifc.byte_valid), 32'd1);
    check("c4_dat",   32'(ifc.byte_out),   32'hC4);
    idle();
    check("c4_one_cycle", 32'(ifc.byte_valid), 32'd0);

    // Five 2s then five 0s with the consumer stalled.
    ifc.byte_ready = 1'b0;
    repeat (5) send_trit(2'd2, 1'b0);
    check("f2_dat", 32'(ifc.byte_out), 32'hF2);
    repeat (4) send_trit(2'd0, 1'b0);
    ifc.trit_in    = 2'd0;
    ifc.trit_valid = 1'b1;
    ifc.trit_last  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_trit_ready", 32'(ifc.trit_ready), 32'd0);
      check("stall_f2_dat",     32'(ifc.byte_out),   32'hF2);
    end
    @(posedge clk);
    #1;
    ifc.byte_ready = 1'b1;
    send_trit(2'd0, 1'b0);
    check("b2b_valid", 32'(ifc.byte_valid), 32'd1);
    check("b2b_dat",   32'(ifc.byte_out),   32'h00);
    idle();

    // Partial group closed by trit_last, then a fresh group from t0.
    send_trit(2'd2, 1'b0);
    send_trit(2'd1, 1'b1);
    check("partial_dat",  32'(ifc.byte_out),  32'd5);
    check("partial_last", 32'(ifc.byte_last), 32'd1);
    send_trit(2'd1, 1'b0);
    repeat (4) send_trit(2'd0, 1'b0);
    check("restart_dat",  32'(ifc.byte_out),  32'h01);
    check("restart_last", 32'(ifc.byte_last), 32'd0);

    // trit 3 behaves like 0.
    send_trit(2'd1, 1'b0);
    send_trit(2'd3, 1'b0);
    send_trit(2'd2, 1'b0);
    send_trit(2'd0, 1'b0);
    send_trit(2'd1, 1'b0);
    check("trit3_dat", 32'(ifc.byte_out), 32'd100);
    send_trit(2'd1, 1'b0);
    send_trit(2'd0, 1'b0);
    send_trit(2'd2, 1'b0);
    send_trit(2'd0, 1'b0);
    send_trit(2'd1, 1'b0);
    check("trit0_dat", 32'(ifc.byte_out), 32'd100);
    idle();

    // Reset in the middle of a group discards it.
    base_bytes = bytes_seen;
    repeat (3) send_trit(2'd2, 1'b0);
    idle();
    pulse_reset();
    idle();
    check("rst_no_byte", 32'(bytes_seen), 32'(base_bytes));
    send_trit(2'd1, 1'b0);
    repeat (4) send_trit(2'd0, 1'b0);
    check("post_rst_dat", 32'(ifc.byte_out), 32'h01);
    idle();

    // One full polynomial of random trits with random consumer stalls.
    pulse_reset();
    base_bytes = bytes_seen;
    base_lasts = lasts_seen;
    rnd_ready  = 1'b1;
    for (int i = 0; i < 700; i++) begin
      t = 2'($urandom_range(0, 3));
      send_trit(t, 1'b0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    rnd_ready      = 1'b0;
    ifc.byte_ready = 1'b1;
    repeat (5) idle();
    check("rand_byte_count", 32'(bytes_seen - base_bytes), 32'd140);
    check("rand_last_count", 32'(lasts_seen - base_lasts), 32'd1);
    check("rand_last_index", 32'(last_at - base_bytes - 1), 32'd139);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
